// File: rtl/spi_xfer_scheduler.sv
// Arbitrated one-byte SPI transfer scheduler driving the master load/start/read controls.
// Define SPI_SCHED_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module spi_xfer_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int XFER_CYCLES = 16
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 busy,
    output logic [7:0]           din_master,
    output logic                 ld_master,
    output logic                 start,
    output logic                 rd_master,
    input  logic [7:0]           dout_master
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(XFER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XFER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any;
    logic [IDX_W-1:0] w_grant;
    logic [7:0]       w_grantData;
    logic             w_accept;

`ifdef SPI_SCHED_RR_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_start;

    assign w_start = (r_ptr == IDX_W'(NUM_REQ - 1)) ? '0 : r_ptr + 1'b1;

    // Search outward from the slot after the last winner; offset k is the priority rank.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int s = 0; s < NUM_REQ; s++) begin
                if (!w_any && (w_start == IDX_W'(s)) && req_valid[(s + k) % NUM_REQ]) begin
                    w_any   = 1'b1;
                    w_grant = IDX_W'((s + k) % NUM_REQ);
                end
            end
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_grant;
        end
    end
`else
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any   = 1'b1;
                w_grant = IDX_W'(i);
            end
        end
    end
`endif

    assign w_accept = (r_state == S_IDLE) && w_any;

    always_comb begin
        w_grantData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_grantData = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_LOAD;
            S_LOAD:  w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_READ;
            S_READ:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Counter is loaded with XFER_CYCLES-1 in START so WAIT spans exactly XFER_CYCLES cycles.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_tx    <= '0;
            r_rx    <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_tx    <= w_grantData;
                r_owner <= w_grant;
            end
            if (r_state == S_START) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == S_READ) begin
                r_rx <= dout_master;
            end
        end
    end

    // The accept pulse is masked while reset is held so no grant is shown for a request
    // that the held-in-reset registers cannot take.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && !rst && (w_grant == IDX_W'(i));
            rsp_valid[i] = (r_state == S_RESP) && (r_owner == IDX_W'(i));
        end
    end

    assign ld_master  = (r_state == S_LOAD);
    assign start      = (r_state == S_START);
    assign rd_master  = (r_state == S_READ);
    assign busy       = (r_state != S_IDLE);
    assign din_master = r_tx;
    assign rsp_data   = r_rx;

endmodule
